mlp_train_ctrl: RTL
===================

Name: mlp_train_ctrl

Overview:
- Companion/feeder for the MLP branch predictor: drives `predict_features` at fetch and generates the `train_en` / `train_pc` / `train_features` / `actual_taken` stream when branches resolve in EX.
- Keeps a speculative global history register (GHR) and a committed GHR.
- Holds an in-order FIFO of in-flight predicted branches; each entry is {pc, feature snapshot, predicted direction}.
- On misprediction it repairs history and discards wrong-path entries.

Parameters:
- FEATURES, 32, GHR width; equals predictor FEATURES.
- DEPTH, 8, in-flight branch queue entries; power of two, ≥2.
- TAG_W, $clog2(DEPTH), tag/pointer width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_valid  in  1  conditional branch predicted in IF this cycle.
- fetch_pc  in  32  PC of that branch.
- pred_taken  in  1  predictor `prediction` for `fetch_pc`.
- pred_features  out  FEATURES  current speculative GHR; wired to the predictor's `predict_features`.
- fetch_ready  out  1  queue has space; fetch stalls when 0.
- fetch_tag  out  TAG_W  tag given to the branch pushed this cycle (= write pointer).
- resolve_valid  in  1  oldest in-flight branch resolved in EX.
- resolve_tag  in  TAG_W  tag carried down the pipe.
- resolve_taken  in  1  actual direction.
- flush_all  in  1  exception/redirect; kill all in-flight branches.
- train_en  out  1  one-cycle pulse to the predictor.
- train_pc  out  32  PC of the trained branch.
- train_features  out  FEATURES  snapshot taken at prediction time.
- actual_taken  out  1  resolved direction.
- mispredict  out  1  one-cycle pulse, registered with `train_en`.
- occupancy  out  TAG_W+1  entries in flight.
- tag_error  out  1  sticky protocol-violation flag.

Behaviour:
- **Reset** (async, rst_n=0):
  - Queue empty; rd/wr pointers 0.
  - spec_ghr = 0, arch_ghr = 0.
  - train_en, train_pc, train_features, actual_taken, mispredict, tag_error all 0.
  - fetch_ready = 1, occupancy = 0.
  - Reset mid-operation drops all entries, with no train pulse.
- **Combinational outputs:** fetch_ready = (count < DEPTH); pred_features = spec_ghr; fetch_tag = wr_ptr.
  - fetch_ready ignores a same-cycle pop: a full queue never accepts a push, even while popping.
- **Push** (fetch_valid & fetch_ready):
  - Write {fetch_pc, spec_ghr, pred_taken} at wr_ptr; wr_ptr++ with wrap mod DEPTH.
  - spec_ghr <= {spec_ghr[F-2:0], pred_taken}.
- **Resolve** (resolve_valid & count>0):
  - Pop the head entry.
  - Next cycle: train_en=1, train_pc=head.pc, train_features=head.features, actual_taken=resolve_taken, mispredict=(resolve_taken != head.pred).
  - arch_ghr <= {arch_ghr[F-2:0], resolve_taken}.
  - Latency resolve→train_en is exactly 1 cycle; the train outputs hold their values until the next pulse.
- **Mispredict resolve:**
  - All younger entries are discarded: count <= 0, wr_ptr <= rd_ptr+1.
  - spec_ghr <= {head.features[F-2:0], resolve_taken}.
  - A push in the same cycle is dropped (wrong path).
- **Correct resolve with a same-cycle push:** both take effect; count is unchanged.
- **Protocol errors:**
  - resolve_valid with count=0: ignored, no train pulse, tag_error <= 1.
  - resolve_tag != rd_ptr: tag_error <= 1; the pop and train still proceed.
  - tag_error clears only on reset.
- **flush_all** (highest priority):
  - Queue emptied; pointers equalised at wr_ptr.
  - Same-cycle push dropped.
  - spec_ghr <= arch_ghr including any same-cycle resolve shift.
  - A same-cycle valid resolve still pops first and produces its train pulse.
- **Priority:** flush_all > mispredict resolve > push. Correct resolve and push are concurrent.
- **Wrap-around:** pointers wrap mod DEPTH. count distinguishes full from empty.

Decomposition:
- Package mlp_bp_pkg holds:
  - FEATURES default.
  - Entry struct: pc[31:0], features, pred.
  - TAG_W derivation.
- One sub-module, mlp_bq_fifo: storage, pointers, count, and a truncate-to-head operation.
- History logic and the train output register stay in the top level.

Test Plan:
- Push pc 0x100 (pred=1), then 0x104 (pred=0); resolve tag0 taken, tag1 not-taken → two train pulses with correct PCs, features 0x0 then 0x1, mispredict 0, occupancy back to 0.
- Push 3 branches, all pred=1; resolve tag0 not-taken → mispredict=1, occupancy 0, spec_ghr = 0x0 (snapshot 0 shifted with 0), wr_ptr=1.
- Push 8 with no resolve → fetch_ready=0 and a 9th push is ignored; one correct resolve in the same cycle as a push attempt → push rejected, occupancy 7.
- Resolve with an empty queue → no train_en, tag_error=1 and it stays high until rst_n low.
- 4 pushes plus flush_all in the same cycle as resolve tag0 taken → one train pulse, occupancy 0, spec_ghr = arch_ghr = 0x1.
- Assert rst_n low asynchronously mid-stream with 5 in flight → outputs 0 immediately, fetch_ready=1, no train pulse after release.

Source files
------------

// File: rtl/mlp_bp_pkg.sv
// Shared definitions for the MLP branch-predictor feeder.
//   FEATURES_DFLT : default global-history width (matches the predictor)
//   DEPTH_DFLT    : default in-flight branch queue depth
//   bq_entry_t    : queue entry layout {pc, feature snapshot, predicted dir}
//   tag_w()       : tag/pointer width for a given queue depth
package mlp_bp_pkg;

  localparam int FEATURES_DFLT = 32;
  localparam int DEPTH_DFLT    = 8;
  localparam int PC_W          = 32;

  // Entry layout at the default history width. The top level declares the
  // same shape locally so that a FEATURES override keeps the fields aligned.
  typedef struct packed {
    logic [PC_W-1:0]          pc;
    logic [FEATURES_DFLT-1:0] features;
    logic                     pred;
  } bq_entry_t;

  function automatic int tag_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mlp_bq_fifo.sv
// In-order queue of in-flight predicted branches.
//   push/push_data : append an entry at wr_ptr
//   pop            : drop the head entry (rd_ptr advances)
//   flush          : empty the queue, rd_ptr <= wr_ptr (pointers equalised)
//   truncate       : pop the head and discard everything younger
//                    (wr_ptr <= rd_ptr+1); caller asserts pop with it
//   head_data      : entry at rd_ptr
//   rd_ptr/wr_ptr  : pointers, wrap mod DEPTH
//   count          : entries held, 0..DEPTH (distinguishes full from empty)
module mlp_bq_fifo
  import mlp_bp_pkg::*;
#(
  parameter int W     = PC_W + FEATURES_DFLT + 1,
  parameter int DEPTH = DEPTH_DFLT,
  parameter int TAG_W = tag_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  input  logic             flush,
  input  logic             truncate,
  output logic [W-1:0]     head_data,
  output logic [TAG_W-1:0] rd_ptr,
  output logic [TAG_W-1:0] wr_ptr,
  output logic [TAG_W:0]   count
);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [TAG_W-1:0]        rd_q, rd_d, wr_q, wr_d;
  logic [TAG_W:0]          cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = wr_q;
      cnt_d = '0;
    end else if (truncate) begin
      // Head is consumed and the whole wrong path behind it vanishes.
      rd_d  = rd_q + TAG_W'(1);
      wr_d  = rd_q + TAG_W'(1);
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_data;
        wr_d        = wr_q + TAG_W'(1);
      end
      if (pop) rd_d = rd_q + TAG_W'(1);
      cnt_d = cnt_q + {{TAG_W{1'b0}}, push} - {{TAG_W{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_data = mem_q[rd_q];
  assign rd_ptr    = rd_q;
  assign wr_ptr    = wr_q;
  assign count     = cnt_q;

endmodule

// File: rtl/mlp_train_ctrl.sv
// Feeder for the MLP branch predictor.
// Supplies the speculative global history at fetch, queues every predicted
// branch with its history snapshot, and emits a registered training beat
// when the oldest branch resolves. Mispredicts and flushes repair history.
//   fetch_*        : branch predicted in IF (push), fetch_ready/fetch_tag back
//   pred_features  : speculative GHR to the predictor
//   resolve_*      : oldest branch resolved in EX (pop)
//   flush_all      : kill every in-flight branch, restore committed GHR
//   train_*        : one-cycle training pulse, values held between pulses
//   mispredict     : pulses with train_en when the prediction was wrong
//   occupancy      : entries in flight
//   tag_error      : sticky protocol-violation flag (clears on reset only)
module mlp_train_ctrl
  import mlp_bp_pkg::*;
#(
  parameter int FEATURES = FEATURES_DFLT,
  parameter int DEPTH    = DEPTH_DFLT,
  parameter int TAG_W    = tag_w(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fetch_valid,
  input  logic [31:0]         fetch_pc,
  input  logic                pred_taken,
  output logic [FEATURES-1:0] pred_features,
  output logic                fetch_ready,
  output logic [TAG_W-1:0]    fetch_tag,
  input  logic                resolve_valid,
  input  logic [TAG_W-1:0]    resolve_tag,
  input  logic                resolve_taken,
  input  logic                flush_all,
  output logic                train_en,
  output logic [31:0]         train_pc,
  output logic [FEATURES-1:0] train_features,
  output logic                actual_taken,
  output logic                mispredict,
  output logic [TAG_W:0]      occupancy,
  output logic                tag_error
);

  typedef struct packed {
    logic [PC_W-1:0]     pc;
    logic [FEATURES-1:0] features;
    logic                pred;
  } entry_t;

  localparam int             ENTRY_W   = $bits(entry_t);
  localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);

  entry_t               head, push_entry;
  logic [ENTRY_W-1:0]   head_raw;
  logic [TAG_W-1:0]     rd_ptr, wr_ptr;
  logic [TAG_W:0]       count;
  logic                 do_pop, do_push, mis, truncate;

  logic [FEATURES-1:0]  spec_ghr_q, spec_ghr_d;
  logic [FEATURES-1:0]  arch_ghr_q, arch_ghr_d;
  logic                 train_en_q, train_en_d;
  logic [31:0]          train_pc_q, train_pc_d;
  logic [FEATURES-1:0]  train_feat_q, train_feat_d;
  logic                 actual_q, actual_d;
  logic                 mispred_q, mispred_d;
  logic                 tag_err_q, tag_err_d;

  // A full queue never accepts, even when the head pops this cycle.
  assign fetch_ready = (count < DEPTH_CNT);
  assign head        = entry_t'(head_raw);

  assign do_pop   = resolve_valid && (count != '0);
  assign mis      = do_pop && (resolve_taken != head.pred);
  // Anything fetched alongside a flush or a mispredict is wrong-path.
  assign do_push  = fetch_valid && fetch_ready && !flush_all && !mis;
  assign truncate = mis && !flush_all;

  assign push_entry = '{pc: fetch_pc, features: spec_ghr_q, pred: pred_taken};

  mlp_bq_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (do_push),
    .push_data (push_entry),
    .pop       (do_pop),
    .flush     (flush_all),
    .truncate  (truncate),
    .head_data (head_raw),
    .rd_ptr    (rd_ptr),
    .wr_ptr    (wr_ptr),
    .count     (count)
  );

  always_comb begin
    arch_ghr_d = arch_ghr_q;
    if (do_pop) arch_ghr_d = {arch_ghr_q[FEATURES-2:0], resolve_taken};

    spec_ghr_d = spec_ghr_q;
    if (flush_all)
      spec_ghr_d = arch_ghr_d;           // includes this cycle's resolve
    else if (mis)
      spec_ghr_d = {head.features[FEATURES-2:0], resolve_taken};
    else if (do_push)
      spec_ghr_d = {spec_ghr_q[FEATURES-2:0], pred_taken};

    train_en_d   = do_pop;
    mispred_d    = mis;
    train_pc_d   = train_pc_q;
    train_feat_d = train_feat_q;
    actual_d     = actual_q;
    if (do_pop) begin
      train_pc_d   = head.pc;
      train_feat_d = head.features;
      actual_d     = resolve_taken;
    end

    tag_err_d = tag_err_q
              | (resolve_valid && (count == '0))
              | (do_pop && (resolve_tag != rd_ptr));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_ghr_q   <= '0;
      arch_ghr_q   <= '0;
      train_en_q   <= 1'b0;
      train_pc_q   <= '0;
      train_feat_q <= '0;
      actual_q     <= 1'b0;
      mispred_q    <= 1'b0;
      tag_err_q    <= 1'b0;
    end else begin
      spec_ghr_q   <= spec_ghr_d;
      arch_ghr_q   <= arch_ghr_d;
      train_en_q   <= train_en_d;
      train_pc_q   <= train_pc_d;
      train_feat_q <= train_feat_d;
      actual_q     <= actual_d;
      mispred_q    <= mispred_d;
      tag_err_q    <= tag_err_d;
    end
  end

  assign pred_features  = spec_ghr_q;
  assign fetch_tag      = wr_ptr;
  assign occupancy      = count;
  assign train_en       = train_en_q;
  assign train_pc       = train_pc_q;
  assign train_features = train_feat_q;
  assign actual_taken   = actual_q;
  assign mispredict     = mispred_q;
  assign tag_error      = tag_err_q;

endmodule
